// File: rtl/dadda_dot_acc_pkg.sv
// Shared types and widths for the Dadda dot-product accumulator.
package dadda_dot_acc_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/dadda_dot_acc_sat_add.sv
// Accumulator adder: one extra carry bit, clamps to all-ones on overflow.
module dot_acc_sat_add
  import dadda_dot_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign ovf_o    = full_sum[ACC_W];
  assign sum_o    = ovf_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
endmodule

// File: rtl/dadda_dot_acc.sv
// Sequential dot-product wrapper around an external combinational 8x8 multiplier.
// state | meaning
// IDLE  | no vector in progress, accepting
// ACCUM | vector in progress, accepting further terms
// DRAIN | last term accepted, waiting for it to be summed
// HOLD  | result presented, waiting for res_ready
module dadda_dot_acc
  import dadda_dot_acc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   in_a_i,
  input  logic [OP_W-1:0]   in_b_i,
  input  logic              in_last_i,
  output logic [OP_W-1:0]   mul_a_o,
  output logic [OP_W-1:0]   mul_b_o,
  input  logic [PROD_W-1:0] mul_p_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  res_data_o,
  output logic [CNT_W-1:0]  res_cnt_o,
  output logic              res_sat_o
);
  state_e              state_q;
  logic [OP_W-1:0]     mul_a_q, mul_b_q;
  logic                s0_v_q, s0_last_q, s1_v_q, s1_last_q;
  logic [PROD_W-1:0]   prod_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sticky_q, ovf_d;
  logic                res_valid_q, res_sat_q;
  logic [ACC_W-1:0]    res_data_q;
  logic [CNT_W-1:0]    res_cnt_q;
  logic                accept;

  assign in_ready_o = !rst_i && ((state_q == IDLE) || (state_q == ACCUM));
  assign accept     = in_valid_i && in_ready_o;
  assign cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  dot_acc_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (prod_q),
    .sum_o  (acc_d),
    .ovf_o  (ovf_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s0_v_q      <= 1'b0;
      s0_last_q   <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      s0_v_q    <= accept;
      s0_last_q <= accept && in_last_i;
      if (accept) begin
        mul_a_q <= in_a_i;
        mul_b_q <= in_b_i;
      end
      s1_v_q    <= s0_v_q;
      s1_last_q <= s0_last_q;
      if (s0_v_q) prod_q <= mul_p_i;
      // The last term goes straight into the result registers and restarts the accumulator.
      if (s1_v_q) begin
        if (s1_last_q) begin
          res_data_q  <= acc_d;
          res_cnt_q   <= cnt_d;
          res_sat_q   <= sticky_q | ovf_d;
          res_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          sticky_q    <= 1'b0;
        end else begin
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          sticky_q <= sticky_q | ovf_d;
        end
      end
      case (state_q)
        IDLE:    if (accept) state_q <= in_last_i ? DRAIN : ACCUM;
        ACCUM:   if (accept && in_last_i) state_q <= DRAIN;
        DRAIN:   if (s1_v_q && s1_last_q) state_q <= HOLD;
        HOLD: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_cnt_o   = res_cnt_q;
  assign res_sat_o   = res_sat_q;
endmodule

// File: tb/tb_dadda_dot_acc.sv
// Directed bench: two instances (ACC_W=24 and ACC_W=16) share one stimulus stream.
module tb_dadda_dot_acc;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, res_ready;
  logic [7:0]  in_a, in_b;

  logic        rdy24, rv24, sat24;
  logic [7:0]  ma24, mb24, cnt24;
  logic [15:0] mp24;
  logic [23:0] rd24;

  logic        rdy16, rv16, sat16;
  logic [7:0]  ma16, mb16, cnt16;
  logic [15:0] mp16;
  logic [15:0] rd16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mp24 = ma24 * mb24;
  assign mp16 = ma16 * mb16;

  dadda_dot_acc #(.ACC_W(24), .CNT_W(8)) dut24 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy24),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .mul_a_o(ma24), .mul_b_o(mb24), .mul_p_i(mp24),
    .res_valid_o(rv24), .res_ready_i(res_ready), .res_data_o(rd24),
    .res_cnt_o(cnt24), .res_sat_o(sat24)
  );

  dadda_dot_acc #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy16),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .mul_a_o(ma16), .mul_b_o(mb16), .mul_p_i(mp16),
    .res_valid_o(rv16), .res_ready_i(res_ready), .res_data_o(rd16),
    .res_cnt_o(cnt16), .res_sat_o(sat16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    #1;
    chk("send_in_ready", {31'd0, rdy24}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    chk("release_res_valid", {31'd0, rv24}, 32'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    in_a = 8'd0; in_b = 8'd0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, rdy24}, 32'd0);
    chk("rst_res_valid", {31'd0, rv24}, 32'd0);
    chk("rst_res_data", {8'd0, rd24}, 32'd0);
    chk("rst_mul_a", {24'd0, ma24}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, rdy24}, 32'd1);

    // single term 3*5
    send(8'd3, 8'd5, 1'b1);
    chk("mul_a_load", {24'd0, ma24}, 32'd3);
    chk("mul_b_load", {24'd0, mb24}, 32'd5);
    chk("drain_in_ready", {31'd0, rdy24}, 32'd0);
    chk("lat1_res_valid", {31'd0, rv24}, 32'd0);
    tick();
    chk("lat2_res_valid", {31'd0, rv24}, 32'd0);
    tick();
    chk("lat3_res_valid", {31'd0, rv24}, 32'd1);
    chk("single_data", {8'd0, rd24}, 32'd15);
    chk("single_cnt", {24'd0, cnt24}, 32'd1);
    chk("single_sat", {31'd0, sat24}, 32'd0);
    release_res();

    // four back-to-back 255*255
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    chk("b2b_in_ready_after", {31'd0, rdy24}, 32'd0);
    tick(); tick();
    chk("b2b_res_valid", {31'd0, rv24}, 32'd1);
    chk("b2b_data", {8'd0, rd24}, 32'd260100);
    chk("b2b_cnt", {24'd0, cnt24}, 32'd4);
    chk("b2b_sat", {31'd0, sat24}, 32'd0);
    chk("b2b16_data", {16'd0, rd16}, 32'd65535);
    chk("b2b16_sat", {31'd0, sat16}, 32'd1);
    release_res();

    // saturation on the 16-bit instance
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    tick(); tick();
    chk("sat16_valid", {31'd0, rv16}, 32'd1);
    chk("sat16_data", {16'd0, rd16}, 32'd65535);
    chk("sat16_sat", {31'd0, sat16}, 32'd1);
    chk("sat24_data", {8'd0, rd24}, 32'd130050);
    chk("sat24_sat", {31'd0, sat24}, 32'd0);
    release_res();

    // sticky must be cleared for the next vector
    send(8'd2, 8'd3, 1'b1);
    tick(); tick();
    chk("after_sat16_data", {16'd0, rd16}, 32'd6);
    chk("after_sat16_sat", {31'd0, sat16}, 32'd0);
    chk("after_sat16_cnt", {24'd0, cnt16}, 32'd1);

    // consumer stall with a new pair waiting
    in_a = 8'd1; in_b = 8'd1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, rv24}, 32'd1);
      chk("stall_data", {8'd0, rd24}, 32'd6);
      chk("stall_cnt", {24'd0, cnt24}, 32'd1);
      chk("stall_in_ready", {31'd0, rdy24}, 32'd0);
    end
    release_res();
    #1;
    chk("post_release_ready", {31'd0, rdy24}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("one_lat2_valid", {31'd0, rv24}, 32'd0);
    tick();
    chk("one_valid", {31'd0, rv24}, 32'd1);
    chk("one_data", {8'd0, rd24}, 32'd1);
    release_res();

    // bubbles in the middle of a vector
    send(8'd10, 8'd10, 1'b0);
    #1;
    chk("bubble_ready", {31'd0, rdy24}, 32'd1);
    tick(); tick();
    send(8'd20, 8'd20, 1'b1);
    tick(); tick();
    chk("bubble_valid", {31'd0, rv24}, 32'd1);
    chk("bubble_data", {8'd0, rd24}, 32'd500);
    chk("bubble_cnt", {24'd0, cnt24}, 32'd2);
    release_res();

    // reset aborts a vector in flight
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    rst = 1'b1;
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    #1;
    chk("abort_rst_ready", {31'd0, rdy24}, 32'd0);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_valid", {31'd0, rv24}, 32'd0);
    end
    chk("abort_res_data", {8'd0, rd24}, 32'd0);
    send(8'd7, 8'd7, 1'b1);
    tick(); tick();
    chk("post_abort_valid", {31'd0, rv24}, 32'd1);
    chk("post_abort_data", {8'd0, rd24}, 32'd49);
    chk("post_abort_cnt", {24'd0, cnt24}, 32'd1);
    release_res();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
